uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL provide parameter: CLKS_PER_BIT, 16, clk cycles per serial bit (min 4, even).
REQ-002 SHALL provide parameter: DATA_BITS, 8, data bits per frame (5..8).
REQ-003 SHALL provide parameter: FIFO_DEPTH, 4, received-word buffer entries (power of 2, >=2).
REQ-004 SHALL provide port: clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL provide port: resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL provide port: pin  input  1  serial line, idle high, asynchronous to clk.
REQ-007 SHALL provide port: rx_data  output  DATA_BITS  head-of-FIFO word, LSB = first received bit.
REQ-008 SHALL provide port: rx_valid  output  1  FIFO non-empty.
REQ-009 SHALL provide port: rx_ready  input  1  consumer accepts rx_data.
REQ-010 SHALL provide port: fill  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-011 SHALL provide port: frame_err  output  1  sticky stop-bit error.
REQ-012 SHALL provide port: overrun_err  output  1  sticky FIFO-full drop.
REQ-013 SHALL provide port: err_clr  input  1  one-cycle pulse clearing sticky errors.

Function
REQ-014 pin SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY (only with UART_RX_PARITY_EN), STOP.
REQ-016 IDLE->START on synchronized pin low; bit counter cleared.
REQ-017 START: at count CLKS_PER_BIT/2-1, pin low -> DATA with counter reset; pin high -> IDLE (glitch reject, nothing pushed, no error).
REQ-018 DATA: sample every CLKS_PER_BIT cycles (mid-bit), shift in LSB first; after DATA_BITS samples -> PARITY or STOP.
REQ-019 STOP: sample at mid-bit; high -> frame good; low -> frame_err set, word discarded; either case -> IDLE.
REQ-020 Good frame SHALL push into FIFO the cycle after the stop sample; rx_valid rises that cycle if FIFO was empty.
REQ-021 Pop occurs on cycles with rx_valid && rx_ready; rx_data SHALL update to next entry the following cycle (first-word-fall-through).
REQ-022 Simultaneous push and pop SHALL both occur; fill unchanged; legal even when full.
REQ-023 Push when full and no pop SHALL drop the new word, set overrun_err; FIFO contents unchanged.
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH; fill SHALL range 0..FIFO_DEPTH.
REQ-025 err_clr SHALL clear both sticky flags; if an error event coincides with err_clr, the flag SHALL remain set.
REQ-026 rx_data SHALL hold its value while rx_valid && !rx_ready.

Reset
REQ-027 resetn low SHALL asynchronously force: FSM IDLE, counters 0, synchronizer flops 1, FIFO empty, fill 0, rx_valid 0, rx_data 0, frame_err 0, overrun_err 0.
REQ-028 Reset mid-frame SHALL abandon the partial word; after release, reception resumes at the next falling edge.

Configuration
REQ-029 Macro UART_RX_PARITY_EN defined: one even-parity bit follows data, sampled mid-bit in PARITY; mismatch sets port parity_err (output 1, sticky, cleared by err_clr, reset 0) and the word is discarded.
REQ-030 Macro UART_RX_PARITY_EN undefined: no PARITY state, no parity_err port; frame = start + DATA_BITS + stop.

Verification
REQ-031 Defaults; send 0xA5 with valid stop, rx_ready=0 -> rx_valid=1, rx_data=0xA5, fill=1, no errors.
REQ-032 Send 0x3C with stop bit low -> frame_err=1, fill=0; err_clr pulse -> frame_err=0.
REQ-033 Low pulse of CLKS_PER_BIT/4 cycles on idle line -> FSM back to IDLE, fill=0, no errors.
REQ-034 Send 5 words 0x01..0x05, rx_ready=0 -> fill=4, overrun_err=1, pop sequence 0x01..0x04.
REQ-035 With FIFO full, assert rx_ready exactly on push cycle -> fill stays 4, no overrun, new word last out.
REQ-036 UART_RX_PARITY_EN defined: send 0x07 with parity bit 0 -> parity_err=1, fill=0; with parity 1 -> rx_data=0x07.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1-style UART receiver feeding a first-word-fall-through FIFO.
//
// Ports:
//   clk          sole clock, rising edge
//   resetn       asynchronous active-low reset
//   pin          serial line (idle high, asynchronous to clk)
//   rx_data      head-of-FIFO word, LSB = first received bit
//   rx_valid     FIFO non-empty
//   rx_ready     consumer accepts rx_data (pop on rx_valid && rx_ready)
//   fill         FIFO occupancy, 0..FIFO_DEPTH
//   frame_err    sticky: stop bit sampled low
//   overrun_err  sticky: word dropped because FIFO was full
//   err_clr      one-cycle pulse clearing the sticky flags
//   parity_err   sticky even-parity mismatch (only with UART_RX_PARITY_EN)
//
// Optional feature: define UART_RX_PARITY_EN to expect one even-parity bit
// after the data bits.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          pin,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill,
    output logic                          frame_err,
    output logic                          overrun_err,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_err,
`endif
    input  logic                          err_clr
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e                 state_q, state_d;
    logic                   pin_s1_q, pin_s2_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   push, frame_ev;
`ifdef UART_RX_PARITY_EN
    logic                   parity_ev;
    logic                   parity_err_q;
`endif

    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [AW:0]            fill_q, fill_d;
    logic                   full, pop, do_push, overrun_ev;
    logic                   frame_err_q, overrun_err_q;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pin_s1_q <= 1'b1;
            pin_s2_q <= 1'b1;
        end else begin
            pin_s1_q <= pin;
            pin_s2_q <= pin_s1_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_ev  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_ev = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                if (!pin_s2_q) state_d = StStart;
            end
            StStart: begin
                // Re-check at mid start bit; a high line here was a glitch.
                if (cnt_q == CW'(CLKS_PER_BIT / 2 - 1)) begin
                    cnt_d   = '0;
                    state_d = pin_s2_q ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d     = '0;
                    shift_d   = {pin_s2_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d = '0;
                    if (pin_s2_q != ^shift_q) begin
                        parity_ev = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        state_d = StStop;
                    end
                end
            end
`endif
            StStop: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    push    = pin_s2_q;
                    frame_ev = !pin_s2_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FIFO: the write lands on the edge ending the stop-sample cycle, so
    // rx_valid rises on the following cycle.
    assign full       = (fill_q == (AW + 1)'(FIFO_DEPTH));
    assign pop        = rx_valid && rx_ready;
    assign do_push    = push && (!full || pop);
    assign overrun_ev = push && full && !pop;

    always_comb begin
        fill_d = fill_q;
        if (do_push && !pop)      fill_d = fill_q + (AW + 1)'(1);
        else if (!do_push && pop) fill_d = fill_q - (AW + 1)'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            fill_q <= fill_d;
        end
    end

    // Sticky flags: a new event wins over a coincident clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q  <= 1'b0;
`endif
        end else begin
            frame_err_q   <= frame_ev   | (frame_err_q   & ~err_clr);
            overrun_err_q <= overrun_ev | (overrun_err_q & ~err_clr);
`ifdef UART_RX_PARITY_EN
            parity_err_q  <= parity_ev  | (parity_err_q  & ~err_clr);
`endif
        end
    end

    assign rx_data     = mem_q[rd_ptr_q];
    assign rx_valid    = (fill_q != '0);
    assign fill        = fill_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with default parameters (16 clocks/bit,
// 8 data bits, 4-entry FIFO). Inputs change on the falling clock edge and
// outputs are checked there too.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       resetn;
    logic       pin;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [2:0] fill;
    logic       frame_err;
    logic       overrun_err;
    logic       err_clr;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLKS_PER_BIT(16),
        .DATA_BITS   (8),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pin        (pin),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fill       (fill),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .err_clr    (err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame: start, 8 data bits LSB first, optional parity, stop.
    // When rdy_pulse is set, rx_ready is high only across the clock edge on
    // which the good-frame push happens (10.5 clocks into the stop bit:
    // 2 synchronizer stages + mid-bit sample).
    task automatic send(input logic [7:0] d, input logic stop_v, input logic par_v,
                        input logic rdy_pulse);
        pin = 1'b0;
        repeat (16) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            pin = d[b];
            repeat (16) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        pin = par_v;
        repeat (16) @(negedge clk);
`endif
        pin = stop_v;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (rdy_pulse && k == 9) rx_ready = 1'b1;
            if (rdy_pulse && k == 10) rx_ready = 1'b0;
        end
        pin = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic clr_pulse();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        resetn   = 1'b0;
        pin      = 1'b1;
        rx_ready = 1'b0;
        err_clr  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", rx_valid, 0);
        chk("reset_fill", fill, 0);
        chk("reset_data", rx_data, 8'h00);
        chk("reset_ferr", frame_err, 0);
        chk("reset_oerr", overrun_err, 0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        // Single good frame, held at the head.
        send(8'hA5, 1'b1, 1'b0, 1'b0);
        chk("a5_valid", rx_valid, 1);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_fill", fill, 1);
        chk("a5_ferr", frame_err, 0);
        chk("a5_oerr", overrun_err, 0);
        repeat (20) @(negedge clk);
        chk("a5_hold", rx_data, 8'hA5);
        pop_one();
        chk("a5_pop_valid", rx_valid, 0);
        chk("a5_pop_fill", fill, 0);

        // Stop bit low: frame error, word discarded, no phantom frame after.
        send(8'h3C, 1'b0, 1'b0, 1'b0);
        chk("3c_ferr", frame_err, 1);
        chk("3c_fill", fill, 0);
        repeat (200) @(negedge clk);
        chk("3c_no_phantom", fill, 0);
        clr_pulse();
        chk("3c_clr", frame_err, 0);

        // Quarter-bit low glitch on the idle line.
        pin = 1'b0;
        repeat (4) @(negedge clk);
        pin = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_fill", fill, 0);
        chk("glitch_ferr", frame_err, 0);
        chk("glitch_oerr", overrun_err, 0);
        send(8'h5A, 1'b1, 1'b0, 1'b0);
        chk("after_glitch_data", rx_data, 8'h5A);
        chk("after_glitch_fill", fill, 1);
        pop_one();

        // Five words into a 4-deep FIFO: last one dropped.
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, ^(8'(i)), 1'b0);
        chk("ovr_fill", fill, 4);
        chk("ovr_flag", overrun_err, 1);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ovr_pop%0d", i), rx_data, i);
            pop_one();
        end
        chk("ovr_empty", fill, 0);
        clr_pulse();
        chk("ovr_clr", overrun_err, 0);

        // Full FIFO, pop exactly on the push edge: both happen.
        for (int i = 8'h11; i <= 8'h14; i++) send(8'(i), 1'b1, ^(8'(i)), 1'b0);
        chk("full_fill", fill, 4);
        send(8'h15, 1'b1, ^(8'h15), 1'b1);
        chk("simul_fill", fill, 4);
        chk("simul_oerr", overrun_err, 0);
        for (int i = 8'h12; i <= 8'h15; i++) begin
            chk($sformatf("simul_pop%0h", i), rx_data, i);
            pop_one();
        end
        chk("simul_empty", fill, 0);

        // Reset in the middle of a frame, then a clean frame.
        pin = 1'b0;
        repeat (40) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("midreset_fill", fill, 0);
        chk("midreset_valid", rx_valid, 0);
        pin = 1'b1;
        repeat (5) @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_reset_idle", fill, 0);
        send(8'h66, 1'b1, ^(8'h66), 1'b0);
        chk("post_reset_data", rx_data, 8'h66);
        chk("post_reset_fill", fill, 1);
        pop_one();

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b0, 1'b0);
        chk("par_bad_err", parity_err, 1);
        chk("par_bad_fill", fill, 0);
        clr_pulse();
        chk("par_clr", parity_err, 0);
        send(8'h07, 1'b1, 1'b1, 1'b0);
        chk("par_good_data", rx_data, 8'h07);
        chk("par_good_err", parity_err, 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
